// File: rtl/half_adder_bit.sv
// Single-lane half-adder cell: sum and carry of two one-bit operands.
module half_adder_bit (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/half_adder.sv
// WIDTH independent half-adder lanes with a combinational output, a valid-qualified
// register stage and a saturating count of transactions that produced a carry.
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_cnt
);

    logic any_carry;
    logic cnt_full;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        half_adder_bit u_bit (
            .a     (a[i]),
            .b     (b[i]),
            .sum   (sum[i]),
            .carry (carry[i])
        );
    end

    assign any_carry = |carry;
    assign cnt_full  = (carry_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q     <= '0;
            carry_q   <= '0;
            out_valid <= 1'b0;
            carry_cnt <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum_q   <= sum;
                carry_q <= carry;
                // Saturate rather than wrap so a long run never reads as few carries.
                if (any_carry && !cnt_full) begin
                    carry_cnt <= carry_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_half_adder.sv
// Self-checking bench: a 4-lane/16-bit-counter instance and a 1-lane/2-bit-counter instance
// driven by vector tables, directed sequences and random stimulus against a lane-sum model.
module tb_half_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;

    logic [3:0] aw = '0, bw = '0;
    logic       vw = 1'b0;
    logic [3:0] sum_w, carry_w, sum_q_w, carry_q_w;
    logic       ov_w;
    logic [15:0] cnt_w;

    logic       an = 1'b0, bn = 1'b0;
    logic       vn = 1'b0;
    logic       sum_n, carry_n, sum_q_n, carry_q_n;
    logic       ov_n;
    logic [1:0] cnt_n;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [3:0] m_sum_w, m_carry_w;
    logic       m_ov_w;
    int         m_cnt_w;
    logic       m_sum_n, m_carry_n;
    logic       m_ov_n;
    int         m_cnt_n;

    half_adder #(.WIDTH(4), .CNT_W(16)) dut_w (
        .clk(clk), .rst(rst), .a(aw), .b(bw), .in_valid(vw),
        .sum(sum_w), .carry(carry_w), .sum_q(sum_q_w), .carry_q(carry_q_w),
        .out_valid(ov_w), .carry_cnt(cnt_w)
    );

    half_adder #(.WIDTH(1), .CNT_W(2)) dut_n (
        .clk(clk), .rst(rst), .a(an), .b(bn), .in_valid(vn),
        .sum(sum_n), .carry(carry_n), .sum_q(sum_q_n), .carry_q(carry_q_n),
        .out_valid(ov_n), .carry_cnt(cnt_n)
    );

    initial begin
        forever begin
            #5;
            if (run) clk = ~clk;
        end
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
        logic [3:0] carry;
    } vec_t;

    vec_t tt1 [4];
    vec_t tt4 [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lane result from the arithmetic sum of the two operand bits.
    function automatic logic [7:0] lane_add(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] s, c;
        for (int i = 0; i < 4; i++) begin
            int t;
            t    = int'(x[i]) + int'(y[i]);
            s[i] = (t % 2) == 1;
            c[i] = (t / 2) == 1;
        end
        return {c, s};
    endfunction

    task automatic model_reset();
        m_sum_w = '0; m_carry_w = '0; m_ov_w = 1'b0; m_cnt_w = 0;
        m_sum_n = 1'b0; m_carry_n = 1'b0; m_ov_n = 1'b0; m_cnt_n = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, " sum_q_w"},   32'(sum_q_w),   32'(m_sum_w));
        check({tag, " carry_q_w"}, 32'(carry_q_w), 32'(m_carry_w));
        check({tag, " ov_w"},      32'(ov_w),      32'(m_ov_w));
        check({tag, " cnt_w"},     32'(cnt_w),     32'(m_cnt_w));
        check({tag, " sum_q_n"},   32'(sum_q_n),   32'(m_sum_n));
        check({tag, " carry_q_n"}, 32'(carry_q_n), 32'(m_carry_n));
        check({tag, " ov_n"},      32'(ov_n),      32'(m_ov_n));
        check({tag, " cnt_n"},     32'(cnt_n),     32'(m_cnt_n));
    endtask

    task automatic check_comb(input string tag);
        logic [7:0] rw, rn;
        rw = lane_add(aw, bw);
        rn = lane_add({3'b0, an}, {3'b0, bn});
        check({tag, " sum_w"},   32'(sum_w),   32'(rw[3:0]));
        check({tag, " carry_w"}, 32'(carry_w), 32'(rw[7:4]));
        check({tag, " sum_n"},   32'(sum_n),   32'(rn[0]));
        check({tag, " carry_n"}, 32'(carry_n), 32'(rn[4]));
    endtask

    // One clock edge: model captures the inputs present at the edge, then outputs are checked.
    task automatic cycle(input string tag);
        logic [7:0] rw, rn;
        rw = lane_add(aw, bw);
        rn = lane_add({3'b0, an}, {3'b0, bn});
        @(posedge clk);
        m_ov_w = vw;
        if (vw) begin
            m_sum_w = rw[3:0]; m_carry_w = rw[7:4];
            if (rw[7:4] != 0 && m_cnt_w < 65535) m_cnt_w++;
        end
        m_ov_n = vn;
        if (vn) begin
            m_sum_n = rn[0]; m_carry_n = rn[4];
            if (rn[4] && m_cnt_n < 3) m_cnt_n++;
        end
        #1;
        check_regs(tag);
        check_comb(tag);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_regs("reset");
        #1;
        rst = 1'b0;
    endtask

    initial begin
        tt1[0] = '{4'h0, 4'h0, 4'h0, 4'h0};
        tt1[1] = '{4'h0, 4'h1, 4'h1, 4'h0};
        tt1[2] = '{4'h1, 4'h0, 4'h1, 4'h0};
        tt1[3] = '{4'h1, 4'h1, 4'h0, 4'h1};
        tt4[0] = '{4'b1100, 4'b1010, 4'b0110, 4'b1000};
        tt4[1] = '{4'b1111, 4'b1111, 4'b0000, 4'b1111};
        tt4[2] = '{4'b0000, 4'b1111, 4'b1111, 4'b0000};
        tt4[3] = '{4'b0101, 4'b0011, 4'b0110, 4'b0001};
        tt4[4] = '{4'b1001, 4'b0110, 4'b1111, 4'b0000};

        #1;
        pulse_reset();

        // Combinational truth tables with the clock idle and reset low.
        for (int i = 0; i < 4; i++) begin
            an = tt1[i].a[0]; bn = tt1[i].b[0];
            #10;
            check($sformatf("tt1[%0d] sum", i),   32'(sum_n),   32'(tt1[i].sum[0]));
            check($sformatf("tt1[%0d] carry", i), 32'(carry_n), 32'(tt1[i].carry[0]));
        end
        for (int i = 0; i < 5; i++) begin
            aw = tt4[i].a; bw = tt4[i].b;
            #10;
            check($sformatf("tt4[%0d] sum", i),   32'(sum_w),   32'(tt4[i].sum));
            check($sformatf("tt4[%0d] carry", i), 32'(carry_w), 32'(tt4[i].carry));
        end
        check_regs("idle");

        run = 1'b1;
        @(posedge clk); #1;
        pulse_reset();

        // Registered latency and hold on the narrow instance.
        an = 1'b1; bn = 1'b1; vn = 1'b1; aw = '0; bw = '0; vw = 1'b0;
        cycle("lat_valid");
        check("lat sum_q", 32'(sum_q_n), 32'd0);
        check("lat carry_q", 32'(carry_q_n), 32'd1);
        check("lat ov", 32'(ov_n), 32'd1);
        check("lat cnt", 32'(cnt_n), 32'd1);
        an = 1'b0; bn = 1'b1; vn = 1'b0;
        cycle("lat_hold");
        check("hold ov", 32'(ov_n), 32'd0);
        check("hold carry_q", 32'(carry_q_n), 32'd1);
        check("hold cnt", 32'(cnt_n), 32'd1);

        // Multi-lane: one valid cycle adds exactly one carry event.
        aw = 4'b1100; bw = 4'b1010; vw = 1'b1;
        cycle("multi");
        check("multi sum_q", 32'(sum_q_w), 32'h6);
        check("multi carry_q", 32'(carry_q_w), 32'h8);
        check("multi cnt", 32'(cnt_w), 32'd1);
        vw = 1'b0;

        // Saturation on the 2-bit counter.
        pulse_reset();
        an = 1'b1; bn = 1'b1; vn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            int exp_cnt;
            exp_cnt = (i + 1 > 3) ? 3 : i + 1;
            cycle($sformatf("sat%0d", i));
            check($sformatf("sat%0d cnt", i), 32'(cnt_n), 32'(exp_cnt));
        end
        bn = 1'b0;
        cycle("sat_nocarry");
        check("sat_nocarry cnt", 32'(cnt_n), 32'd3);
        check("sat_nocarry sum_q", 32'(sum_q_n), 32'd1);

        // Asynchronous reset between edges with a transaction in flight.
        pulse_reset();
        an = 1'b1; bn = 1'b1; vn = 1'b1;
        cycle("pre_rst0");
        cycle("pre_rst1");
        check("pre_rst cnt", 32'(cnt_n), 32'd2);
        check("pre_rst ov", 32'(ov_n), 32'd1);
        #1;
        aw = 4'b0110; bw = 4'b0011;
        rst = 1'b1;
        model_reset();
        #1;
        check_regs("async");
        check("async sum_w", 32'(sum_w), 32'h5);
        check("async carry_w", 32'(carry_w), 32'h2);
        check("async carry_n", 32'(carry_n), 32'd1);
        #1;
        rst = 1'b0;

        // Randomized traffic on both instances against the model.
        for (int i = 0; i < 400; i++) begin
            aw = 4'($urandom); bw = 4'($urandom); vw = 1'($urandom);
            an = 1'($urandom); bn = 1'($urandom); vn = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
